// File: rtl/uart_word_loader_pkg.sv
// Shared types and width helpers for the UART word loader.
package uart_word_loader_pkg;

    // COLLECT assembles bytes, WRITE commits one word, FULL drops input until clear/reset.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        FULL    = 2'd2
    } loader_state_t;

    // $clog2 that never returns 0, so a counter for a value of 1 still has a legal width.
    function automatic int min1_clog2(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_word_loader_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
// Only the read register is reset; the array keeps its contents.
module sdp_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_W) - 1];

    // Write port: array is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered, sees the old word on a same-address write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// Packs UART bytes big-endian into DATA_BYTES-wide words and writes them to
// consecutive RAM addresses, with wrap/stop modes, partial-word timeout and clear.
//
// Handshake: rx_ready is a strobe with no backpressure. A byte is taken on every
// cycle rx_ready is high (except when clear is also high, or while FULL); rx_data
// is only looked at in those cycles.
module uart_word_loader
    import uart_word_loader_pkg::*;
#(
    parameter int DATA_BYTES     = 3,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_ready,
    input  logic                    clear,
    input  logic                    wrap_mode,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [8*DATA_BYTES-1:0] rd_data,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [ADDR_W:0]         word_count,
    output logic                    word_done,
    output logic                    full,
    output logic                    overflow,
    output loader_state_t           dbg_state
);

    localparam int W      = 8 * DATA_BYTES;
    localparam int CNT_W  = min1_clog2(DATA_BYTES);
    localparam int IDLE_W = min1_clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(DATA_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [CNT_W-1:0]  byte_cnt;
    logic [W-1:0]      asm_reg;
    logic [W-1:0]      wr_word;
    logic [W-1:0]      next_asm;
    logic [IDLE_W-1:0] idle_cnt;
    logic [ADDR_W:0]   count_next;
    logic              going_full;
    logic              timeout_hit;
    logic              ram_we;

    // New byte enters at the bottom; after DATA_BYTES shifts the first byte sits on top.
    assign next_asm    = W'({asm_reg, rx_data});
    assign count_next  = (word_count == DEPTH_CNT) ? word_count : word_count + CNT_ONE;
    assign going_full  = !wrap_mode && (count_next == DEPTH_CNT);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (byte_cnt != '0) && !rx_ready
                         && (idle_cnt == IDLE_LAST);
    // A clear in the WRITE cycle aborts the write.
    assign ram_we      = (dbg_state == WRITE) && !clear;

    // Loader FSM with byte counter, assembly register, idle timer and write pointer.
    always_ff @(posedge clk) begin
        word_done <= 1'b0;
        if (reset || clear) begin
            dbg_state  <= COLLECT;
            byte_cnt   <= '0;
            asm_reg    <= '0;
            wr_word    <= '0;
            idle_cnt   <= '0;
            wr_addr    <= '0;
            word_count <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (dbg_state == WRITE) begin
                wr_addr    <= wr_addr + ADDR_W'(1);
                word_count <= count_next;
            end
            case (dbg_state)
                COLLECT, WRITE: begin
                    if (dbg_state == WRITE && going_full) begin
                        // Last slot just written in stop mode; a byte arriving now has nowhere to go.
                        dbg_state <= FULL;
                        full      <= 1'b1;
                        if (rx_ready) begin
                            overflow <= 1'b1;
                        end
                    end else if (rx_ready) begin
                        idle_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            // Latch the finished word so the next word can start assembling during WRITE.
                            wr_word   <= next_asm;
                            asm_reg   <= '0;
                            byte_cnt  <= '0;
                            dbg_state <= WRITE;
                            word_done <= 1'b1;
                        end else begin
                            asm_reg   <= next_asm;
                            byte_cnt  <= byte_cnt + CNT_W'(1);
                            dbg_state <= COLLECT;
                        end
                    end else begin
                        dbg_state <= COLLECT;
                        if (timeout_hit) begin
                            byte_cnt <= '0;
                            asm_reg  <= '0;
                            idle_cnt <= '0;
                        end else if (byte_cnt != '0 && TIMEOUT_CYCLES != 0) begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (rx_ready) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    dbg_state <= COLLECT;
                end
            endcase
        end
    end

    sdp_ram #(
        .WIDTH  (W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_word),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader (3-byte words, 4-entry RAM, 100-cycle timeout).
module tb_uart_word_loader;
    import uart_word_loader_pkg::*;

    localparam int DB = 3;
    localparam int AW = 2;
    localparam int TO = 100;
    localparam int W  = 8 * DB;

    logic          clk;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          clear;
    logic          wrap_mode;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   word_count;
    logic          word_done;
    logic          full;
    logic          overflow;
    loader_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected write addresses, in order, one per word_done pulse.
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] mon_addr;

    uart_word_loader #(
        .DATA_BYTES     (DB),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .clear      (clear),
        .wrap_mode  (wrap_mode),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_addr    (wr_addr),
        .word_count (word_count),
        .word_done  (word_done),
        .full       (full),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drivers: each byte is presented for exactly one rising edge.
    task automatic send_byte(input logic [7:0] b, input logic clr);
        rx_data  = b;
        rx_ready = 1'b1;
        clear    = clr;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic expect_write, input logic [AW-1:0] a);
        send_byte(w[23:16], 1'b0);
        send_byte(w[15:8], 1'b0);
        if (expect_write) exp_q.push_back(a);
        send_byte(w[7:0], 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    // Monitor: every word_done must match the next expected write address.
    always @(negedge clk) begin
        if (!reset && word_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_done_unexpected: got pulse at wr_addr=%0d, expected no pulse", wr_addr);
            end else begin
                mon_addr = exp_q.pop_front();
                if (wr_addr !== mon_addr) begin
                    errors++;
                    $display("FAIL word_done_addr: got %0d, expected %0d", wr_addr, mon_addr);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        errors++;
        checks++;
        $display("FAIL watchdog: got no end of test, expected finish before 2ms");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; clear = 1'b0;
        wrap_mode = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_word_count", 32'(word_count), 32'h0);
        check("rst_word_done", 32'(word_done), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(COLLECT));
        reset = 1'b0;
        idle(1);

        // Basic pack
        send_word(24'h123456, 1'b1, 2'd0);
        idle(2);
        check("basic_wr_addr", 32'(wr_addr), 32'h1);
        check("basic_count", 32'(word_count), 32'h1);
        read_check("basic_data", 2'd0, 24'h123456);

        // Clear coincident with the final byte: nothing written
        pulse_clear();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        idle(2);
        check("clear_wr_addr", 32'(wr_addr), 32'h0);
        check("clear_count", 32'(word_count), 32'h0);
        check("clear_state", 32'(dbg_state), 32'(COLLECT));
        send_word(24'h445566, 1'b1, 2'd0);
        idle(1);
        check("clear_next_addr", 32'(wr_addr), 32'h1);
        read_check("clear_next_data", 2'd0, 24'h445566);

        // Stop mode
        pulse_clear();
        wrap_mode = 1'b0;
        send_word(24'h101112, 1'b1, 2'd0);
        send_word(24'h202122, 1'b1, 2'd1);
        send_word(24'h303132, 1'b1, 2'd2);
        send_word(24'h404142, 1'b1, 2'd3);
        @(negedge clk);
        check("stop_full_not_yet", 32'(full), 32'h0);
        check("stop_in_write", 32'(dbg_state), 32'(WRITE));
        @(negedge clk);
        check("stop_full", 32'(full), 32'h1);
        check("stop_count", 32'(word_count), 32'h4);
        check("stop_wr_addr", 32'(wr_addr), 32'h0);
        check("stop_no_ovf_yet", 32'(overflow), 32'h0);
        send_byte(8'hDE, 1'b0);
        @(negedge clk);
        check("stop_overflow", 32'(overflow), 32'h1);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBF, 1'b0);
        idle(1);
        read_check("stop_addr0_kept", 2'd0, 24'h101112);
        read_check("stop_addr3", 2'd3, 24'h404142);
        wrap_mode = 1'b1;
        idle(3);
        check("stop_wrap_no_exit", 32'(dbg_state), 32'(FULL));
        check("stop_full_held", 32'(full), 32'h1);

        // Reset leaves FULL and clears sticky flags
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        check("rst2_full", 32'(full), 32'h0);
        check("rst2_overflow", 32'(overflow), 32'h0);
        check("rst2_state", 32'(dbg_state), 32'(COLLECT));

        // Wrap mode
        wrap_mode = 1'b1;
        send_word(24'h515253, 1'b1, 2'd0);
        send_word(24'h616263, 1'b1, 2'd1);
        send_word(24'h717273, 1'b1, 2'd2);
        send_word(24'h818283, 1'b1, 2'd3);
        send_word(24'hAABBCC, 1'b1, 2'd0);
        idle(2);
        check("wrap_wr_addr", 32'(wr_addr), 32'h1);
        check("wrap_count_sat", 32'(word_count), 32'h4);
        check("wrap_full", 32'(full), 32'h0);
        read_check("wrap_addr0", 2'd0, 24'hAABBCC);
        read_check("wrap_addr1", 2'd1, 24'h616263);

        // Timeout: partial word discarded
        pulse_clear();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        idle(150);
        send_word(24'h0A0B0C, 1'b1, 2'd0);
        idle(2);
        check("tmo_count", 32'(word_count), 32'h1);
        read_check("tmo_data", 2'd0, 24'h0A0B0C);
        // 99 idle cycles: partial survives
        send_byte(8'h77, 1'b0);
        idle(99);
        send_byte(8'h88, 1'b0);
        exp_q.push_back(2'd1);
        send_byte(8'h99, 1'b0);
        idle(1);
        read_check("tmo_edge_keep", 2'd1, 24'h778899);
        // 100 idle cycles: partial dropped
        send_byte(8'hE1, 1'b0);
        idle(100);
        send_word(24'hF1F2F3, 1'b1, 2'd2);
        idle(1);
        read_check("tmo_edge_drop", 2'd2, 24'hF1F2F3);
        check("tmo_count2", 32'(word_count), 32'h3);

        // Back-to-back bytes, next word starts during WRITE
        pulse_clear();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        exp_q.push_back(2'd0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0);
        exp_q.push_back(2'd1);
        send_byte(8'h06, 1'b0);
        idle(2);
        check("b2b_count", 32'(word_count), 32'h2);
        read_check("b2b_word0", 2'd0, 24'h010203);
        read_check("b2b_word1", 2'd1, 24'h040506);

        // Reset mid-word
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_rd_data", 32'(rd_data), 32'h0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'h0);
        check("mid_rst_count", 32'(word_count), 32'h0);
        check("mid_rst_done", 32'(word_done), 32'h0);
        check("mid_rst_full", 32'(full), 32'h0);
        check("mid_rst_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;
        idle(1);
        send_word(24'hCCDDEE, 1'b1, 2'd0);
        idle(1);
        read_check("mid_rst_next", 2'd0, 24'hCCDDEE);

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Packs the byte stream from `uart_basic` (`rx_data`/`rx_ready`) into words of `DATA_BYTES` bytes and writes them sequentially into an internal simple-dual-port RAM. The RAM has an independent registered read port for display or VGA logic. The block replaces the fixed-address, fixed-width BRAM test path with a parametrised loader. It adds word assembly, an auto-incrementing write pointer, wrap/stop modes, partial-word timeout and a host clear.

## Interface
- `DATA_BYTES`, 3: bytes per RAM word; word width `W = 8*DATA_BYTES`.
- `ADDR_W`, 10: address width; `DEPTH = 2**ADDR_W`.
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles after which a partial word is discarded; 0 disables the timeout.
- `clk` in 1: the single clock for the block.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte, valid only while `rx_ready` is high.
- `rx_ready` in 1: one-cycle strobe per received byte.
- `clear` in 1: synchronous pulse; restarts loading at address 0. RAM contents are kept.
- `wrap_mode` in 1: 1 = pointer wraps to 0 after `DEPTH-1`; 0 = stop when full.
- `rd_addr` in `ADDR_W`: read address.
- `rd_data` out `W`: RAM word at `rd_addr`, registered.
- `wr_addr` out `ADDR_W`: next address to be written.
- `word_count` out `ADDR_W+1`: words written since reset/clear; saturates at `DEPTH`.
- `word_done` out 1: one-cycle pulse per completed word write.
- `full` out 1: high when `wrap_mode=0` and `DEPTH` words have been written.
- `overflow` out 1: sticky; set when a byte arrives while `full`. Cleared only by `reset`/`clear`.

## Operation
- FSM states:
  - `COLLECT`: shift bytes into the assembly register. Byte order is big-endian: the first byte lands in `[W-1:W-8]`.
  - `WRITE`: a one-cycle RAM write of the assembled word at `wr_addr`.
  - `FULL`: all bytes are dropped.
- `COLLECT` → `WRITE` on the `rx_ready` that completes byte `DATA_BYTES-1`. The byte counter returns to 0.
- `WRITE` → `COLLECT` in all cases except `wrap_mode=0` with `word_count` reaching `DEPTH`, which goes → `FULL`.
  - In `WRITE`: `wr_addr` increments modulo `DEPTH`, `word_count` increments (saturating), and `word_done` pulses.
- An `rx_ready` arriving during `WRITE` is accepted into `COLLECT` as byte 0 of the next word. No byte is lost.
- `FULL` is left only by `clear` or `reset`.
  - Changing `wrap_mode` to 1 while in `FULL` does not exit `FULL`.
- Timeout:
  - An idle counter runs while the byte count is nonzero and `rx_ready` is low.
  - At `TIMEOUT_CYCLES` it discards the partial word: byte count goes to 0, assembly register to 0, and nothing is written.
  - Every accepted byte restarts the counter.
- `clear` has priority over `rx_ready` in the same cycle. It discards the partial word, sets `wr_addr` and `word_count` to 0, deasserts `full` and `overflow`, and moves the FSM to `COLLECT`.
  - `clear` during `WRITE` aborts that write.
- `DATA_BYTES=1`: every byte goes `COLLECT` → `WRITE` directly.

## Timing
- Reset values: `rd_data` 0, `wr_addr` 0, `word_count` 0, `word_done` 0, `full` 0, `overflow` 0; FSM in `COLLECT` with byte count 0. RAM contents are not reset.
- Write latency: the RAM write and `word_done` occur in the cycle after the final byte's `rx_ready`. The word is readable at `rd_data` two cycles after that write cycle.
- Read latency: 1 cycle from `rd_addr` to `rd_data`.
- Read and write to the same address in the same cycle: `rd_data` returns the old word (read-first).
- `full` rises in the cycle after the write of word `DEPTH-1`.
- `overflow` rises in the cycle after the offending `rx_ready`.

## Structure
- `uart_word_loader_pkg` contains:
  - the `loader_state_t` enum {`COLLECT`, `WRITE`, `FULL`};
  - a width helper function for `$clog2(DATA_BYTES)` that returns at least 1.
- Sub-module `sdp_ram #(WIDTH, ADDR_W)`: inferred simple dual-port RAM, read-first, registered output, one clock, no reset on the array. It is instantiated once.
- FSM, counters and assembly register live in `uart_word_loader`.

## Test plan
- **Basic pack** (`DATA_BYTES=3`): send 0x12, 0x34, 0x56 → one `word_done` pulse and `wr_addr`=1. `rd_addr`=0 then gives `rd_data`=0x123456 one cycle later.
- **Stop mode** (`ADDR_W=2`, `wrap_mode=0`): send 5 words → `full`=1 after the 4th word and `word_count`=4. The 5th word's bytes set `overflow` and leave addr 0 unchanged.
- **Wrap mode** (`ADDR_W=2`, `wrap_mode=1`): send 5 words, the 5th being 0xAABBCC → addr 0 reads 0xAABBCC, `wr_addr`=1, `word_count`=4 (saturated), `full`=0.
- **Timeout** (`TIMEOUT_CYCLES=100`): send 0x01, 0x02, wait 150 cycles, then send 0x0A, 0x0B, 0x0C → addr 0 = 0x0A0B0C and only one `word_done`.
- **Clear**: `clear` coincident with the 3rd byte's `rx_ready` → no write and `wr_addr`=0. The next 3 bytes land at addr 0.
- **Back-to-back**: `rx_ready` on consecutive cycles for 6 bytes → 2 words written correctly with 2 `word_done` pulses. Also assert `reset` mid-word → all outputs return to their reset values.
